// File: rtl/jtframe_credits_pkg.sv
// Shared encodings and default frame counts for the credits overlay controller
// and the overlay instantiation that has to agree with it.
package jtframe_credits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SHOW   = 2'd2,
        ST_HIDDEN = 2'd3
    } cred_st_t;

    localparam int unsigned TIMEOUT_FR_DEF = 1800;
    localparam int unsigned HOLD_FR_DEF    = 30;
    localparam int unsigned CNTW_DEF       = 12;

endpackage

// File: rtl/jtframe_credits_btn.sv
// Raw button conditioning: 2-flop synchroniser, frame-tick sampled debounce
// and a debounced rising-edge detector valid only in the tick cycle.
module jtframe_credits_btn (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic press
);

    logic s0, s1, smp, db;
    logic settle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0  <= 1'b0;
            s1  <= 1'b0;
            smp <= 1'b0;
            db  <= 1'b0;
        end else begin
            s0 <= btn;
            s1 <= s0;
            if (tick) begin
                smp <= s1;
                if (s1 == smp) db <= s1;
            end
        end
    end

    // level is the debounced value as it stands after this tick
    assign settle = tick && (s1 == smp);
    assign level  = settle ? s1 : db;
    assign press  = settle && s1 && !db;

endmodule

// File: rtl/jtframe_credits_ctrl.sv
// Drives enable/toggle/fast_scroll of the credits overlay from pause and two
// user buttons, keeping a mirror of the overlay's sticky hide flag.
module jtframe_credits_ctrl
    import jtframe_credits_pkg::*;
#(
    parameter logic        BLKPOL     = 1'b1,
    parameter int unsigned TIMEOUT_FR = TIMEOUT_FR_DEF,
    parameter int unsigned HOLD_FR    = HOLD_FR_DEF,
    parameter int unsigned CNTW       = CNTW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       VB,
    input  logic       pause,
    input  logic       btn_toggle,
    input  logic       btn_fast,
    output logic       enable,
    output logic       toggle,
    output logic       fast_scroll,
    output logic [1:0] st_dbg
);

    localparam logic [CNTW-1:0] FR_LAST   = (TIMEOUT_FR != 0) ? CNTW'(TIMEOUT_FR - 1) : '1;
    localparam logic [CNTW-1:0] HOLD_LAST = (HOLD_FR != 0) ? CNTW'(HOLD_FR - 1) : '0;

    cred_st_t        st;
    logic            vb, vb_d, tick;
    logic            tog_press, tog_lvl_unused;
    logic            fast_press, fast_lvl;
    logic            timeout;
    logic            hide_mirror;
    logic [1:0]      rs_cnt;
    logic [CNTW-1:0] frame_cnt, hold_cnt;

    assign vb      = BLKPOL ? VB : ~VB;
    assign tick    = vb && !vb_d;
    assign timeout = (TIMEOUT_FR != 0) && (frame_cnt == FR_LAST);
    assign st_dbg  = st;

    jtframe_credits_btn u_btn_toggle (
        .clk   ( clk            ),
        .rst   ( rst            ),
        .tick  ( tick           ),
        .btn   ( btn_toggle     ),
        .level ( tog_lvl_unused ),
        .press ( tog_press      )
    );

    jtframe_credits_btn u_btn_fast (
        .clk   ( clk        ),
        .rst   ( rst        ),
        .tick  ( tick       ),
        .btn   ( btn_fast   ),
        .level ( fast_lvl   ),
        .press ( fast_press )
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vb_d <= 1'b0;
        else     vb_d <= vb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_IDLE;
            enable      <= 1'b0;
            toggle      <= 1'b0;
            fast_scroll <= 1'b0;
            hide_mirror <= 1'b0;
            rs_cnt      <= '0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
        end else begin
            toggle <= 1'b0;
            if (!pause) begin
                // hide_mirror is kept: the overlay keeps its flag while disabled
                st          <= ST_IDLE;
                enable      <= 1'b0;
                fast_scroll <= 1'b0;
                rs_cnt      <= '0;
                frame_cnt   <= '0;
                hold_cnt    <= '0;
            end else begin
                unique case (st)
                    ST_IDLE: st <= ST_ARM;
                    ST_ARM: begin
                        if (tick) begin
                            st        <= ST_SHOW;
                            enable    <= 1'b1;
                            frame_cnt <= '0;
                            hold_cnt  <= '0;
                            if (hide_mirror) rs_cnt <= 2'd2;
                        end
                    end
                    ST_SHOW: begin
                        if (rs_cnt != 2'd0) begin
                            rs_cnt <= rs_cnt - 2'd1;
                            if (rs_cnt == 2'd1) begin
                                toggle      <= 1'b1;
                                hide_mirror <= 1'b0;
                            end
                        end
                        if (tick) begin
                            if (tog_press || timeout) begin
                                st          <= ST_HIDDEN;
                                fast_scroll <= 1'b0;
                                hold_cnt    <= '0;
                                frame_cnt   <= '0;
                                hide_mirror <= 1'b1;
                                // a hide request during a pending resync just drops
                                // the resync: the overlay is still hidden
                                if (rs_cnt != 2'd0) begin
                                    rs_cnt <= '0;
                                    toggle <= 1'b0;
                                end else begin
                                    toggle <= 1'b1;
                                end
                            end else begin
                                if (fast_press)            frame_cnt <= '0;
                                else if (frame_cnt != FR_LAST) frame_cnt <= frame_cnt + 1'b1;
                                if (fast_lvl) begin
                                    if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
                                    fast_scroll <= (hold_cnt >= HOLD_LAST);
                                end else begin
                                    hold_cnt    <= '0;
                                    fast_scroll <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_HIDDEN: begin
                        fast_scroll <= 1'b0;
                        hold_cnt    <= '0;
                        if (tick && tog_press) begin
                            st          <= ST_SHOW;
                            toggle      <= 1'b1;
                            hide_mirror <= 1'b0;
                            frame_cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_credits_ctrl.sv
// Directed bench for jtframe_credits_ctrl: toggle pulses are checked against a
// queue of expected (frame, phase) positions; levels are checked inline.
module tb_jtframe_credits_ctrl;

    logic       clk = 1'b0;
    logic       rst, VB, pause, btn_toggle, btn_fast;
    logic       enable, toggle, fast_scroll;
    logic [1:0] st_dbg;

    int total = 0;
    int bad   = 0;
    int tick_cnt, phase;
    int exp_q[$];
    logic prev_tog = 1'b0;

    jtframe_credits_ctrl #(
        .BLKPOL     ( 1'b1 ),
        .TIMEOUT_FR ( 4    ),
        .HOLD_FR    ( 3    ),
        .CNTW       ( 12   )
    ) dut (
        .clk         ( clk         ),
        .rst         ( rst         ),
        .VB          ( VB          ),
        .pause       ( pause       ),
        .btn_toggle  ( btn_toggle  ),
        .btn_fast    ( btn_fast    ),
        .enable      ( enable      ),
        .toggle      ( toggle      ),
        .fast_scroll ( fast_scroll ),
        .st_dbg      ( st_dbg      )
    );

    always #5 clk = ~clk;

    // 20-clk frames, VB high for the last 4; tick_cnt counts VB rises
    initial begin
        phase    = 0;
        tick_cnt = 0;
        VB       = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase == 19) ? 0 : phase + 1;
            VB    = (phase >= 16);
            if (phase == 16) tick_cnt++;
        end
    end

    // toggle monitor: every pulse must match the head of the expected queue
    initial begin
        int key, exp_key;
        forever begin
            @(posedge clk); #1;
            if (toggle === 1'b1) begin
                key     = tick_cnt * 100 + phase;
                exp_key = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total++;
                assert (key == exp_key) else begin
                    bad++;
                    $error("FAIL toggle_pos observed=%0d expected=%0d", key, exp_key);
                end
                total++;
                assert (enable === 1'b1 && prev_tog === 1'b0) else begin
                    bad++;
                    $error("FAIL toggle_shape observed enable=%0b prev=%0b expected enable=1 prev=0",
                           enable, prev_tog);
                end
            end
            prev_tog = toggle;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t, input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(tick_cnt == t && phase == ph) && n < 5000);
        total++;
        assert (n < 5000) else begin
            bad++;
            $error("FAIL goto_bound observed=%0d/%0d expected=%0d/%0d", tick_cnt, phase, t, ph);
        end
    endtask

    task automatic sample();
        @(posedge clk); #1;
    endtask

    initial begin
        int te, s, r;
        rst = 1'b1; pause = 1'b0; btn_toggle = 1'b0; btn_fast = 1'b0;
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_toggle", toggle, 0);
        chk("rst_fast", fast_scroll, 0);
        chk("rst_st", st_dbg, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // pause mid-frame: ARM, then SHOW one clk after the next VB rise
        goto(1, 5);
        pause = 1'b1;
        sample();
        chk("arm_st", st_dbg, 1);
        chk("arm_enable", enable, 0);
        goto(2, 16);
        chk("arm_wait_enable", enable, 0);
        chk("arm_wait_st", st_dbg, 1);
        sample();
        chk("show_enable", enable, 1);
        chk("show_st", st_dbg, 2);
        te = tick_cnt;

        // toggle held 3 frames: one pulse on the second tick, then hidden
        goto(te, 2);
        btn_toggle = 1'b1;
        exp_q.push_back((te + 2) * 100 + 16);
        goto(te + 2, 16);
        sample();
        chk("hide_st", st_dbg, 3);
        goto(te + 3, 2);
        btn_toggle = 1'b0;
        goto(te + 5, 2);
        btn_toggle = 1'b1;
        exp_q.push_back((te + 7) * 100 + 16);
        goto(te + 7, 16);
        sample();
        chk("unhide_st", st_dbg, 2);
        goto(te + 8, 2);
        btn_toggle = 1'b0;

        // no activity: timeout pulse on the 4th tick after re-entering SHOW
        exp_q.push_back((te + 11) * 100 + 16);
        goto(te + 10, 16);
        sample();
        chk("pre_timeout_st", st_dbg, 2);
        goto(te + 11, 16);
        sample();
        chk("timeout_st", st_dbg, 3);

        // back to SHOW, then a fast press at tick 2 delays the timeout to tick 6
        goto(te + 12, 2);
        btn_toggle = 1'b1;
        exp_q.push_back((te + 14) * 100 + 16);
        goto(te + 14, 16);
        sample();
        chk("reshow_st", st_dbg, 2);
        s = te + 14;
        goto(s, 2);
        btn_fast = 1'b1;
        goto(s + 1, 2);
        btn_toggle = 1'b0;
        exp_q.push_back((s + 6) * 100 + 16);
        goto(s + 3, 16);
        sample();
        chk("hold_not_yet", fast_scroll, 0);
        goto(s + 4, 16);
        sample();
        chk("hold_fast_on", fast_scroll, 1);
        chk("hold_st", st_dbg, 2);
        goto(s + 4, 2);
        btn_fast = 1'b0;
        goto(s + 5, 16);
        sample();
        chk("release_still_db", fast_scroll, 1);
        goto(s + 6, 16);
        sample();
        chk("late_timeout_fast", fast_scroll, 0);
        chk("late_timeout_st", st_dbg, 3);

        // hidden, pause 1->0->1: re-arm and resync pulse 2 clks after enable
        goto(s + 7, 2);
        pause = 1'b0;
        sample();
        chk("unpause_enable", enable, 0);
        chk("unpause_st", st_dbg, 0);
        @(negedge clk); #2;
        pause = 1'b1;
        sample();
        chk("repause_st", st_dbg, 1);
        r = s + 8;
        exp_q.push_back(r * 100 + 18);
        goto(r, 16);
        chk("rearm_enable_low", enable, 0);
        sample();
        chk("rearm_enable", enable, 1);
        chk("rearm_st", st_dbg, 2);

        // pause falls on the same tick as a toggle press: pause wins
        goto(r, 2);
        btn_toggle = 1'b1;
        goto(r + 2, 16);
        pause = 1'b0;
        sample();
        chk("race_toggle", toggle, 0);
        chk("race_enable", enable, 0);
        chk("race_st", st_dbg, 0);
        btn_toggle = 1'b0;

        // async reset while showing
        goto(r + 3, 5);
        pause = 1'b1;
        goto(r + 4, 16);
        sample();
        chk("pre_rst_st", st_dbg, 2);
        goto(r + 5, 5);
        rst = 1'b1;
        #1;
        chk("async_rst_enable", enable, 0);
        chk("async_rst_toggle", toggle, 0);
        chk("async_rst_fast", fast_scroll, 0);
        chk("async_rst_st", st_dbg, 0);
        pause = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        chk("final_st", st_dbg, 0);
        chk("pending_pulses", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
